// File: rtl/sgd_tree_lane_packer.sv
// Packs a serial stream of signed 32-bit products into a LANES-wide vector for the ternary adder tree.
// Optional SGD_PACK_FLUSH_EN adds a flush input that closes a partial vector like s_last.
module sgd_tree_lane_packer #(
  parameter int LANES        = 9,
  parameter int ACTIVE_LANES = 8,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [31:0]          s_data,
  input  logic                        s_valid,
  input  logic                        s_last,
`ifdef SGD_PACK_FLUSH_EN
  input  logic                        flush,
`endif
  output logic                        s_ready,
  output logic signed [31:0]          v_output [LANES-1:0],
  output logic                        v_output_valid,
  output logic [CNT_WIDTH-1:0]        vec_count
);

  localparam int IDX_W = (ACTIVE_LANES > 1) ? $clog2(ACTIVE_LANES) : 1;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic signed [31:0]     staging_q [LANES-1:0];
  logic signed [31:0]     staging_d [LANES-1:0];
  logic signed [31:0]     merged    [LANES-1:0];
  logic signed [31:0]     out_q     [LANES-1:0];
  logic signed [31:0]     out_d     [LANES-1:0];
  logic                   valid_q, valid_d;
  logic                   ready_q, ready_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   accept;
  logic                   close;

  always_comb begin
    accept  = s_valid && ready_q;
    ready_d = 1'b1;
    merged  = staging_q;
    // Only active lanes are ever written, so lanes >= ACTIVE_LANES stay zero.
    for (int i = 0; i < ACTIVE_LANES; i++) begin
      if (accept && (idx_q == IDX_W'(i))) merged[i] = s_data;
    end

    close = accept && (s_last || (idx_q == IDX_W'(ACTIVE_LANES - 1)));
`ifdef SGD_PACK_FLUSH_EN
    if (flush && ((state_q == FILL) || accept)) close = 1'b1;
`endif

    staging_d = merged;
    idx_d     = idx_q;
    state_d   = state_q;
    out_d     = out_q;
    valid_d   = 1'b0;
    cnt_d     = cnt_q;

    if (close) begin
      out_d     = merged;
      valid_d   = 1'b1;
      cnt_d     = cnt_q + 1'b1;
      staging_d = '{default: '0};
      idx_d     = '0;
      state_d   = IDLE;
    end else if (accept) begin
      idx_d   = idx_q + 1'b1;
      state_d = FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      staging_q <= '{default: '0};
      out_q     <= '{default: '0};
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      staging_q <= staging_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s_ready        = ready_q;
  assign v_output       = out_q;
  assign v_output_valid = valid_q;
  assign vec_count      = cnt_q;

endmodule
